// File: rtl/alu_issue_stage.sv
// alu_issue_stage: command FIFO in front of an external combinational 8-bit ALU,
// with a registered result slot and valid/ready handshakes on both sides.
// Chained commands take operand a from the low byte of the last issued result.
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_a,
  input  logic [7:0]    in_b,
  input  logic [3:0]    in_op,
  input  logic          in_chain,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [3:0]    alu_op,
  input  logic [8:0]    alu_z,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [8:0]    out_z,
  output logic [3:0]    out_op,
  output logic          out_zero,
  output logic          out_carry,
  output logic          out_div0,
  output logic          out_illegal,
  output logic [CW-1:0] fifo_count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic       chain;
  } entry_t;

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } state_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      acc;
  state_t          state;
  logic            fifo_empty;
  logic            push;
  logic            issue;

  assign fifo_empty = (count == '0);
  assign in_ready   = (count < CW'(DEPTH));
  assign push       = in_valid && in_ready;
  // The slot can take a new result when it is empty or being drained this cycle.
  assign issue      = !fifo_empty && ((state == S_EMPTY) || out_ready);
  assign head       = mem[rd_ptr];
  assign out_valid  = (state == S_FULL);
  assign fifo_count = count;

  // Present the FIFO head to the ALU; chained entries substitute the accumulator.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (!fifo_empty) begin
      alu_a  = head.chain ? acc : head.a;
      alu_b  = head.b;
      alu_op = head.op;
    end
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: in_a, b: in_b, op: in_op, chain: in_chain};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Result slot FSM: capture ALU result and flags on issue, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_EMPTY;
      acc         <= '0;
      out_z       <= '0;
      out_op      <= '0;
      out_zero    <= 1'b0;
      out_carry   <= 1'b0;
      out_div0    <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      if (issue) begin
        state       <= S_FULL;
        acc         <= alu_z[7:0];
        out_z       <= alu_z;
        out_op      <= head.op;
        out_zero    <= (alu_z == '0);
        out_carry   <= alu_z[8];
        out_div0    <= (head.op == 4'd2) && (alu_b == '0);
        out_illegal <= (head.op > 4'd9);
      end else if ((state == S_FULL) && out_ready) begin
        state <= S_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: an ALU model drives alu_z, expected
// results are computed in command order at acceptance and popped by a monitor.
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [3:0] in_op;
  logic       in_chain;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_op;
  logic [8:0] alu_z;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_z;
  logic [3:0] out_op;
  logic       out_zero;
  logic       out_carry;
  logic       out_div0;
  logic       out_illegal;
  logic [2:0] fifo_count;

  typedef struct {
    logic [8:0] z;
    logic [3:0] op;
    logic       div0;
    logic       illegal;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_acc;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DEPTH(4), .CW(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_chain(in_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_op(out_op), .out_zero(out_zero), .out_carry(out_carry),
    .out_div0(out_div0), .out_illegal(out_illegal), .fifo_count(fifo_count)
  );

  // Behavioural ALU: 0 add, 1 sub, 2 div, 3 and, 4 or, 5 xor, 6 mul, 7 shl, 8 shr, 9 not.
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] op);
    int unsigned ai = a;
    int unsigned bi = b;
    int unsigned r;
    case (op)
      4'd0:    r = ai + bi;
      4'd1:    r = ai - bi;
      4'd2:    r = (bi == 0) ? 0 : ai / bi;
      4'd3:    r = ai & bi;
      4'd4:    r = ai | bi;
      4'd5:    r = ai ^ bi;
      4'd6:    r = ai * bi;
      4'd7:    r = ai << 1;
      4'd8:    r = ai >> 1;
      4'd9:    r = 255 - ai;
      default: r = 0;
    endcase
    return 9'(r);
  endfunction

  assign alu_z = alu_f(alu_a, alu_b, alu_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Results leave the DUT in acceptance order; chain uses the previous command's result.
  task automatic model_accept();
    logic [7:0] a_eff;
    logic [8:0] z;
    exp_t e;
    a_eff = in_chain ? model_acc : in_a;
    z = alu_f(a_eff, in_b, in_op);
    model_acc = z[7:0];
    e.z = z;
    e.op = in_op;
    e.div0 = (in_op == 4'd2) && (in_b == 8'd0);
    e.illegal = (in_op > 4'd9);
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus; acceptance is judged mid-cycle before the next edge.
  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, input logic ch, input logic ordy);
    @(posedge clk);
    #1;
    in_valid = v; in_a = a; in_b = b; in_op = op; in_chain = ch; out_ready = ordy;
    @(negedge clk);
    if (in_valid && in_ready && !rst) model_accept();
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0, ordy);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      idle(1'b1);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: a transfer occurs at the next edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_z", 32'(out_z), 32'(e.z));
        check("out_op", 32'(out_op), 32'(e.op));
        check("out_zero", 32'(out_zero), 32'(e.z == 9'd0));
        check("out_carry", 32'(out_carry), 32'(e.z[8]));
        check("out_div0", 32'(out_div0), 32'(e.div0));
        check("out_illegal", 32'(out_illegal), 32'(e.illegal));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_chain = 1'b0;
    out_ready = 1'b0;
    model_acc = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_z", 32'(out_z), 32'd0);
    check("rst_alu_a_empty", 32'(alu_a), 32'd0);

    // Single add with minimum latency
    drive(1'b1, 8'd200, 8'd100, 4'd0, 1'b0, 1'b1);
    idle(1'b1);
    check("lat_not_yet_valid", 32'(out_valid), 32'd0);
    idle(1'b1);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("add_z", 32'(out_z), 32'h12C);
    check("add_carry", 32'(out_carry), 32'd1);
    drain();

    // Chain: second command takes a from the first result
    drive(1'b1, 8'd5, 8'd3, 4'd0, 1'b0, 1'b1);
    drive(1'b1, 8'd99, 8'd2, 4'd1, 1'b1, 1'b1);
    idle(1'b1);
    check("chain_first_z", 32'(out_z), 32'd8);
    check("chain_alu_a", 32'(alu_a), 32'd8);
    idle(1'b1);
    check("chain_second_z", 32'(out_z), 32'd6);
    drain();

    // Divide by zero
    drive(1'b1, 8'd9, 8'd0, 4'd2, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("div0_flag", 32'(out_div0), 32'd1);
    check("div0_zero", 32'(out_zero), 32'd1);
    check("div0_illegal", 32'(out_illegal), 32'd0);
    drain();

    // Illegal opcode
    drive(1'b1, 8'd7, 8'd7, 4'hF, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("illegal_flag", 32'(out_illegal), 32'd1);
    check("illegal_z", 32'(out_z), 32'd0);
    drain();

    // Backpressure: 7 offered, 5 accepted
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 9)), 1'($urandom), 1'b0);
    end
    idle(1'b0);
    check("bp_accepted", 32'(exp_q.size()), 32'd5);
    check("bp_fifo_count", 32'(fifo_count), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    idle(1'b0);
    check("bp_out_z_held", 32'(out_z), 32'(exp_q[0].z));
    drain();
    check("bp_fifo_empty", 32'(fifo_count), 32'd0);

    // Reset mid-stream
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 9)), 1'b0, 1'b0);
    end
    idle(1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    model_acc = 8'h00;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_fifo_count", 32'(fifo_count), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 8'($urandom), 8'd4, 4'd0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("mrst_chain_z", 32'(out_z), 32'd4);
    drain();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 9) < 7),
            8'($urandom),
            ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
            4'($urandom),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 9) < 6));
    end
    drain();
    check("final_fifo_count", 32'(fifo_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
